// File: rtl/sound_arbiter.sv
// sound_arbiter
// Arbitrates three sound sources (alarm > jingle > click) onto one piezo.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   req_alarm  level request; alarm loops tone/silence while held
//   req_jingle one-cycle pulse; three-note jingle (buffered one-deep during alarm)
//   req_click  one-cycle pulse; short click (dropped unless idle)
//   mute       level; forces piezo_out low without affecting sequencing
//   piezo_out  square wave to the piezo
//   grant      current owner: 00 none, 01 click, 10 jingle, 11 alarm
//   busy       high whenever a sound owns the output
//   done       one-cycle pulse when a click or jingle completes normally
module sound_arbiter #(
    parameter int MS_DIV   = 50000,
    parameter int HP_CLICK = 12500,
    parameter int HP_ALARM = 25000,
    parameter int HP_J0    = 47801,
    parameter int HP_J1    = 37936,
    parameter int HP_J2    = 31888
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_alarm,
    input  logic       req_jingle,
    input  logic       req_click,
    input  logic       mute,
    output logic       piezo_out,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done
);
    localparam int            PW         = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(MS_DIV - 1);
    localparam logic [7:0]    MS_CLICK   = 8'd20;
    localparam logic [7:0]    MS_NOTE    = 8'd150;
    localparam logic [7:0]    MS_GAP     = 8'd10;
    localparam logic [7:0]    MS_ALARM   = 8'd100;

    typedef enum logic [2:0] {IDLE, CLICK, JNOTE, JGAP, ALM_ON, ALM_OFF} state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg;
    logic [7:0]    ms_reg;
    logic [15:0]   hp_cnt_reg;
    logic          tone_reg;
    logic [1:0]    note_reg, note_next;
    logic          pending_reg, pending_next;
    logic          done_reg, done_next;
    logic [1:0]    grant_reg, grant_next;

    logic [7:0]    dur_ms;
    logic [15:0]   hp_sel;
    logic          sounding;
    logic          time_up;

    // Jingle note half-period table; entry 3 is never selected and mirrors note 2.
    logic [15:0] note_hp [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_note_hp
            localparam int HP = (gi == 0) ? HP_J0 : (gi == 1) ? HP_J1 : HP_J2;
            assign note_hp[gi] = 16'(HP);
        end
    endgenerate

    // Per-state duration and tone selection.
    always_comb begin
        dur_ms   = MS_CLICK;
        hp_sel   = 16'(HP_CLICK);
        sounding = 1'b0;
        case (state_reg)
            CLICK: begin
                dur_ms   = MS_CLICK;
                hp_sel   = 16'(HP_CLICK);
                sounding = 1'b1;
            end
            JNOTE: begin
                dur_ms   = MS_NOTE;
                hp_sel   = note_hp[note_reg];
                sounding = 1'b1;
            end
            JGAP:    dur_ms = MS_GAP;
            ALM_ON: begin
                dur_ms   = MS_ALARM;
                hp_sel   = 16'(HP_ALARM);
                sounding = 1'b1;
            end
            ALM_OFF: dur_ms = MS_ALARM;
            default: ;
        endcase
    end

    // Last clock of the current state's N ms window.
    assign time_up = (presc_reg == PRESC_LAST) && (ms_reg == dur_ms - 8'd1);

    always_comb begin
        state_next   = state_reg;
        note_next    = note_reg;
        pending_next = pending_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_alarm) begin
                    state_next = ALM_ON;
                end else if (req_jingle || pending_reg) begin
                    state_next   = JNOTE;
                    note_next    = 2'd0;
                    pending_next = 1'b0;
                end else if (req_click) begin
                    state_next = CLICK;
                end
            end
            CLICK: begin
                if (req_alarm) begin
                    state_next = ALM_ON;
                end else if (req_jingle) begin
                    state_next = JNOTE;
                    note_next  = 2'd0;
                end else if (time_up) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            JNOTE: begin
                if (req_alarm) begin
                    state_next = ALM_ON;
                end else if (time_up) begin
                    if (note_reg == 2'd2) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = JGAP;
                    end
                end
            end
            JGAP: begin
                if (req_alarm) begin
                    state_next = ALM_ON;
                end else if (time_up) begin
                    state_next = JNOTE;
                    note_next  = note_reg + 2'd1;
                end
            end
            ALM_ON, ALM_OFF: begin
                // A jingle requested during the alarm waits in a one-deep buffer.
                if (req_jingle) begin
                    pending_next = 1'b1;
                end
                if (!req_alarm) begin
                    state_next = IDLE;
                end else if (time_up) begin
                    state_next = (state_reg == ALM_ON) ? ALM_OFF : ALM_ON;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (state_next)
            CLICK:           grant_next = 2'b01;
            JNOTE, JGAP:     grant_next = 2'b10;
            ALM_ON, ALM_OFF: grant_next = 2'b11;
            default:         grant_next = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            note_reg    <= 2'd0;
            pending_reg <= 1'b0;
            done_reg    <= 1'b0;
            grant_reg   <= 2'b00;
            presc_reg   <= '0;
            ms_reg      <= 8'd0;
            hp_cnt_reg  <= 16'd0;
            tone_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            note_reg    <= note_next;
            pending_reg <= pending_next;
            done_reg    <= done_next;
            grant_reg   <= grant_next;
            // Every state entry restarts both the ms timer and the tone phase.
            if (state_next != state_reg || state_reg == IDLE) begin
                presc_reg  <= '0;
                ms_reg     <= 8'd0;
                hp_cnt_reg <= 16'd0;
                tone_reg   <= 1'b0;
            end else begin
                if (presc_reg == PRESC_LAST) begin
                    presc_reg <= '0;
                    ms_reg    <= ms_reg + 8'd1;
                end else begin
                    presc_reg <= presc_reg + PW'(1);
                end
                if (sounding) begin
                    if (hp_cnt_reg == hp_sel - 16'd1) begin
                        hp_cnt_reg <= 16'd0;
                        tone_reg   <= ~tone_reg;
                    end else begin
                        hp_cnt_reg <= hp_cnt_reg + 16'd1;
                    end
                end
            end
        end
    end

    // Mute only gates the output; the tone keeps running underneath.
    assign piezo_out = tone_reg & ~mute;
    assign grant     = grant_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;

endmodule

// File: tb/tb_sound_arbiter.sv
module tb_sound_arbiter;
    localparam int MSD       = 10;
    localparam int HPC       = 2;
    localparam int HPA       = 3;
    localparam int HPJ0      = 4;
    localparam int HPJ1      = 3;
    localparam int HPJ2      = 2;
    localparam int CLICK_LEN = 20 * MSD;
    localparam int NOTE_LEN  = 150 * MSD;
    localparam int GAP_LEN   = 10 * MSD;
    localparam int ALARM_LEN = 100 * MSD;
    localparam int JING_LEN  = 3 * NOTE_LEN + 2 * GAP_LEN;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_alarm = 1'b0;
    logic       req_jingle = 1'b0;
    logic       req_click = 1'b0;
    logic       mute = 1'b0;
    logic       piezo_out;
    logic [1:0] grant;
    logic       busy;
    logic       done;

    sound_arbiter #(
        .MS_DIV(MSD), .HP_CLICK(HPC), .HP_ALARM(HPA),
        .HP_J0(HPJ0), .HP_J1(HPJ1), .HP_J2(HPJ2)
    ) dut (
        .clk(clk), .rst(rst), .req_alarm(req_alarm), .req_jingle(req_jingle),
        .req_click(req_click), .mute(mute), .piezo_out(piezo_out),
        .grant(grant), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       tag;
        logic [1:0] grant;
        logic     done;
    } ev_t;

    typedef struct {
        int   tag;
        logic piezo;
        logic busy;
    } cy_t;

    ev_t ev_q[$];
    cy_t cy_q[$];
    int  errors = 0;
    int  checks = 0;

    // Reference model: owner (0 none, 1 click, 2 jingle, 3 alarm), edge index
    // at which the owner started, and the buffered jingle flag.
    int m_own = 0;
    int m_start = 0;
    bit m_pend = 0;

    // Expected unmuted piezo level from elapsed cycles since the sound began.
    function automatic bit model_piezo(int own, int eo);
        int seg, off, hp, ph;
        case (own)
            1: return ((eo / HPC) % 2) == 1;
            2: begin
                seg = eo / (NOTE_LEN + GAP_LEN);
                off = eo % (NOTE_LEN + GAP_LEN);
                if (off >= NOTE_LEN) return 1'b0;
                hp = (seg == 0) ? HPJ0 : (seg == 1) ? HPJ1 : HPJ2;
                return ((off / hp) % 2) == 1;
            end
            3: begin
                ph = eo % (2 * ALARM_LEN);
                if (ph >= ALARM_LEN) return 1'b0;
                return ((ph / HPA) % 2) == 1;
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_enter(int own);
        m_own   = own;
        m_start = cyc;
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        int  prev;
        int  e;
        bit  nd;
        ev_t ev;
        cy_t c;
        prev = m_own;
        nd   = 1'b0;
        if (rst) begin
            m_own  = 0;
            m_pend = 1'b0;
        end else begin
            e = cyc - m_start;
            case (m_own)
                0: begin
                    if (req_alarm) model_enter(3);
                    else if (req_jingle || m_pend) begin
                        model_enter(2);
                        m_pend = 1'b0;
                    end else if (req_click) model_enter(1);
                end
                1: begin
                    if (req_alarm) model_enter(3);
                    else if (req_jingle) model_enter(2);
                    else if (e == CLICK_LEN) begin
                        m_own = 0;
                        nd    = 1'b1;
                    end
                end
                2: begin
                    if (req_alarm) model_enter(3);
                    else if (e == JING_LEN) begin
                        m_own = 0;
                        nd    = 1'b1;
                    end
                end
                default: begin
                    if (req_jingle) m_pend = 1'b1;
                    if (!req_alarm) m_own = 0;
                end
            endcase
        end
        if (m_own != prev || nd) begin
            ev.tag   = cyc + 1;
            ev.grant = 2'(m_own);
            ev.done  = nd;
            ev_q.push_back(ev);
        end
        c.tag   = cyc + 1;
        c.piezo = (m_own != 0) ? model_piezo(m_own, cyc - m_start) : 1'b0;
        c.busy  = (m_own != 0);
        cy_q.push_back(c);
    endtask

    // Monitor: per-cycle tone/busy stream plus grant/done events.
    logic [1:0] last_grant = 2'b00;
    always @(negedge clk) begin
        ev_t ev;
        cy_t cr;
        if (cy_q.size() > 0) begin
            cr = cy_q.pop_front();
            checks++;
            if (piezo_out !== (cr.piezo & ~mute) || busy !== cr.busy || cr.tag != cyc) begin
                errors++;
                $display("FAIL cycle_out cyc=%0d: piezo=%b busy=%b, required piezo=%b busy=%b",
                         cyc, piezo_out, busy, cr.piezo & ~mute, cr.busy);
            end
        end
        if (grant !== last_grant || done !== 1'b0) begin
            checks++;
            if (ev_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d: grant=%b done=%b, required no event",
                         cyc, grant, done);
            end else begin
                ev = ev_q.pop_front();
                if (ev.tag != cyc || ev.grant !== grant || ev.done !== done) begin
                    errors++;
                    $display("FAIL event cyc=%0d: grant=%b done=%b, required cyc=%0d grant=%b done=%b",
                             cyc, grant, done, ev.tag, ev.grant, ev.done);
                end else begin
                    $display("event cyc=%0d grant=%b done=%b", cyc, grant, done);
                end
            end
        end
        last_grant = grant;
    end

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        req_jingle = 1'b0;
        req_click  = 1'b0;
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_idle(string tag);
        check({tag, "_grant"}, int'(grant), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_piezo"}, int'(piezo_out), 0);
    endtask

    initial begin
        // Reset, with a request held during reset that must be ignored.
        rst = 1'b1;
        req_click = 1'b1;
        cycles(3);
        check_idle("reset");
        rst = 1'b0;
        cycles(2);
        check("idle_after_reset_grant", int'(grant), 0);

        // Scenario 1: click.
        req_click = 1'b1;
        cycle();
        check("click_grant", int'(grant), 1);
        check("click_busy", int'(busy), 1);
        cycles(CLICK_LEN + 20);

        // Scenario 2: full jingle.
        req_jingle = 1'b1;
        cycle();
        check("jingle_grant", int'(grant), 2);
        cycles(JING_LEN + 50);

        // Scenario 3: alarm preempts jingle during note 1, loops, then drops.
        req_jingle = 1'b1;
        cycle();
        cycles(NOTE_LEN + GAP_LEN + 400);
        req_alarm = 1'b1;
        cycle();
        check("alarm_grant", int'(grant), 3);
        cycles(2 * ALARM_LEN + 500);

        // Scenario 4: jingle buffered and click dropped during alarm.
        req_jingle = 1'b1;
        cycle();
        req_click = 1'b1;
        cycles(300);
        req_alarm = 1'b0;
        cycle();
        check("alarm_drop_grant", int'(grant), 0);
        cycle();
        check("pending_jingle_grant", int'(grant), 2);
        cycles(JING_LEN + 50);

        // Scenario 5: simultaneous jingle+click, then click during jingle.
        req_jingle = 1'b1;
        req_click  = 1'b1;
        cycle();
        check("simul_grant", int'(grant), 2);
        cycles(500);
        req_click = 1'b1;
        cycles(JING_LEN);

        // Scenario 6: mute during click, then reset mid-jingle.
        req_click = 1'b1;
        cycles(30);
        mute = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("muted_piezo", int'(piezo_out), 0);
        end
        cycles(CLICK_LEN);
        mute = 1'b0;
        req_jingle = 1'b1;
        cycles(2000);
        rst = 1'b1;
        cycle();
        check_idle("mid_jingle_reset");
        rst = 1'b0;
        cycles(20);

        // Reset during alarm must also clear a buffered jingle.
        req_alarm = 1'b1;
        cycles(10);
        req_jingle = 1'b1;
        cycles(10);
        rst = 1'b1;
        req_alarm = 1'b0;
        cycles(2);
        check_idle("alarm_reset");
        rst = 1'b0;
        cycles(50);
        check("pending_cleared_grant", int'(grant), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 199) == 0) req_click = 1'b1;
            if ($urandom_range(0, 899) == 0) req_jingle = 1'b1;
            if (!req_alarm && $urandom_range(0, 2999) == 0) req_alarm = 1'b1;
            else if (req_alarm && $urandom_range(0, 1199) == 0) req_alarm = 1'b0;
            if ($urandom_range(0, 299) == 0) mute = ~mute;
            rst = ($urandom_range(0, 3999) == 0);
            cycle();
        end
        rst = 1'b0;
        req_alarm = 1'b0;
        mute = 1'b0;
        cycles(5);
        @(negedge clk);
        #1;
        check("event_queue_drained", ev_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
